// File: rtl/mac_pkg.sv
// Shared types and constants for the systolic-MAC job sequencer.
// Holds the FSM state encoding, operand-mode encoding and job-size helpers.
package mac_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    LOAD_D,
    WAIT_RES,
    DRAIN
  } state_e;

  localparam logic MODE_WEIGHT = 1'b1;
  localparam logic MODE_DATA   = 1'b0;

  localparam int unsigned DEF_N = 2;

  function automatic int unsigned nn_of(input int unsigned n);
    return n * n;
  endfunction

  function automatic int unsigned job_len_of(input int unsigned n);
    return 2 * n * n;
  endfunction

  // Address width that never collapses to zero for a single-entry buffer.
  function automatic int unsigned addr_w(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  localparam int unsigned NN      = nn_of(DEF_N);
  localparam int unsigned JOB_LEN = job_len_of(DEF_N);

endpackage

// File: rtl/mac_seq_buf.sv
// DEPTH x W register file: synchronous write, combinational read.
// Used for both the operand buffer and the result buffer of mac_seq.
module mac_seq_buf #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 8,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mac_seq.sv
// Job sequencer in front of the NxN systolic MAC: buffers a job of operands,
// streams weights then data into the MAC, captures its results and drains them.
module mac_seq
  import mac_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned N       = DEF_N,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_v_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  input  logic         start_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_timeout_o,
  output logic         mac_data_v_o,
  output logic         mac_data_mode_o,
  output logic         mac_data_rst_addr_o,
  output logic [W-1:0] mac_data_o,
  input  logic         mac_result_v_i,
  input  logic [W-1:0] mac_result_i,
  output logic         res_v_o,
  output logic [W-1:0] res_data_o,
  input  logic         res_ready_i
);

  localparam int unsigned JNN  = nn_of(N);
  localparam int unsigned JLEN = job_len_of(N);
  localparam int unsigned OAW  = addr_w(JLEN);
  localparam int unsigned RAW  = addr_w(JNN);
  localparam int unsigned OCW  = $clog2(JLEN + 1);
  localparam int unsigned RCW  = $clog2(JNN + 1);
  localparam int unsigned TCW  = $clog2(TIMEOUT + 1);

  state_e         state_q, state_d;
  logic [OCW-1:0] opnd_cnt_q, opnd_cnt_d;
  logic [RCW-1:0] res_cnt_q, res_cnt_d;
  logic [OAW-1:0] ld_ptr_q, ld_ptr_d;
  logic [RCW-1:0] rd_ptr_q, rd_ptr_d;
  logic [TCW-1:0] to_cnt_q, to_cnt_d;
  logic           err_q, err_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           in_ready_q, in_ready_d;
  logic           mac_v_q, mac_v_d;
  logic           mac_mode_q, mac_mode_d;
  logic           mac_rst_addr_q, mac_rst_addr_d;
  logic [W-1:0]   mac_data_q, mac_data_d;
  logic           res_v_q, res_v_d;
  logic [W-1:0]   res_data_q, res_data_d;

  logic           opnd_we, res_we, res_cap, load;
  logic [W-1:0]   opnd_rdata, res_rdata;

  mac_seq_buf #(.DEPTH(JLEN), .W(W), .AW(OAW)) u_opnd_buf (
    .clk     (clk),
    .we_i    (opnd_we),
    .waddr_i (OAW'(opnd_cnt_q)),
    .wdata_i (in_data_i),
    .raddr_i (ld_ptr_d),
    .rdata_o (opnd_rdata)
  );

  mac_seq_buf #(.DEPTH(JNN), .W(W), .AW(RAW)) u_res_buf (
    .clk     (clk),
    .we_i    (res_we),
    .waddr_i (RAW'(res_cnt_q)),
    .wdata_i (mac_result_i),
    .raddr_i (RAW'(rd_ptr_d)),
    .rdata_o (res_rdata)
  );

  // Next state, counters and pointers.
  always_comb begin
    state_d    = state_q;
    opnd_cnt_d = opnd_cnt_q;
    res_cnt_d  = res_cnt_q;
    ld_ptr_d   = ld_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    to_cnt_d   = to_cnt_q;
    err_d      = err_q;
    done_d     = 1'b0;
    opnd_we    = 1'b0;
    res_we     = 1'b0;
    res_cap    = mac_result_v_i && ((state_q == LOAD_D) || (state_q == WAIT_RES))
                 && (res_cnt_q < RCW'(JNN));

    if (res_cap) begin
      res_we    = 1'b1;
      res_cnt_d = res_cnt_q + RCW'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (in_v_i && in_ready_q) begin
          opnd_we    = 1'b1;
          opnd_cnt_d = opnd_cnt_q + OCW'(1);
        end
        // Start is judged on the count before any coincident beat.
        if (start_i && (opnd_cnt_q == OCW'(JLEN))) begin
          state_d   = LOAD_W;
          err_d     = 1'b0;
          res_cnt_d = '0;
          rd_ptr_d  = '0;
          ld_ptr_d  = '0;
        end
      end
      LOAD_W: begin
        ld_ptr_d = ld_ptr_q + OAW'(1);
        if (ld_ptr_q == OAW'(JNN - 1)) begin
          state_d = LOAD_D;
        end
      end
      LOAD_D: begin
        if (ld_ptr_q == OAW'(JLEN - 1)) begin
          state_d  = WAIT_RES;
          ld_ptr_d = '0;
          to_cnt_d = '0;
        end else begin
          ld_ptr_d = ld_ptr_q + OAW'(1);
        end
      end
      WAIT_RES: begin
        to_cnt_d = res_cap ? '0 : (to_cnt_q + TCW'(1));
        if (res_cnt_q == RCW'(JNN)) begin
          state_d = DRAIN;
        end else if (!res_cap && (to_cnt_q == TCW'(TIMEOUT - 1))) begin
          err_d = 1'b1;
          if (res_cnt_q == '0) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            opnd_cnt_d = '0;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (res_v_q && res_ready_i) begin
          rd_ptr_d = rd_ptr_q + RCW'(1);
          if (rd_ptr_q == (res_cnt_q - RCW'(1))) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            opnd_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered output values derived from the next state.
  always_comb begin
    busy_d         = (state_d != IDLE);
    in_ready_d     = (state_d == IDLE) && (opnd_cnt_d < OCW'(JLEN));
    load           = (state_d == LOAD_W) || (state_d == LOAD_D);
    mac_v_d        = load;
    mac_mode_d     = (state_d == LOAD_W) ? MODE_WEIGHT : MODE_DATA;
    mac_rst_addr_d = load && ((ld_ptr_d == '0) || (ld_ptr_d == OAW'(JNN)));
    mac_data_d     = load ? opnd_rdata : '0;
    res_v_d        = (state_d == DRAIN) && (rd_ptr_d < res_cnt_d);
    res_data_d     = res_v_d ? res_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      opnd_cnt_q     <= '0;
      res_cnt_q      <= '0;
      ld_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      to_cnt_q       <= '0;
      err_q          <= 1'b0;
      done_q         <= 1'b0;
      busy_q         <= 1'b0;
      in_ready_q     <= 1'b1;
      mac_v_q        <= 1'b0;
      mac_mode_q     <= 1'b0;
      mac_rst_addr_q <= 1'b0;
      mac_data_q     <= '0;
      res_v_q        <= 1'b0;
      res_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      opnd_cnt_q     <= opnd_cnt_d;
      res_cnt_q      <= res_cnt_d;
      ld_ptr_q       <= ld_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      to_cnt_q       <= to_cnt_d;
      err_q          <= err_d;
      done_q         <= done_d;
      busy_q         <= busy_d;
      in_ready_q     <= in_ready_d;
      mac_v_q        <= mac_v_d;
      mac_mode_q     <= mac_mode_d;
      mac_rst_addr_q <= mac_rst_addr_d;
      mac_data_q     <= mac_data_d;
      res_v_q        <= res_v_d;
      res_data_q     <= res_data_d;
    end
  end

  assign in_ready_o          = in_ready_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign err_timeout_o       = err_q;
  assign mac_data_v_o        = mac_v_q;
  assign mac_data_mode_o     = mac_mode_q;
  assign mac_data_rst_addr_o = mac_rst_addr_q;
  assign mac_data_o          = mac_data_q;
  assign res_v_o             = res_v_q;
  assign res_data_o          = res_data_q;

endmodule

// File: doc/mac_seq.md
Name: mac_seq

Overview:
- Job sequencer in front of the N×N systolic MAC.
- Accepts a job of 2·N·N operand bytes from a host-side valid/ready stream: N·N weights, then N·N data.
- On start, streams the weights into the MAC (weight mode), then the data (data mode), then captures the N·N result beats into a local buffer.
- Drains the results to the host over a valid/ready stream; the MAC results have no backpressure, so this block absorbs them.
- Sits between the pin/boundary-scan interface and the MAC; a timeout flags a MAC that never answers.

Parameters:
- W, 8, operand/result width in bits.
- N, 2, systolic array dimension; a job is 2·N·N operands and yields N·N results.
- TIMEOUT, 15, max cycles between result beats in WAIT_RES before err_timeout_o is raised.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- in_v_i  in  1  operand beat valid.
- in_data_i  in  W  operand.
- in_ready_o  out  1  operand buffer can accept.
- start_i  in  1  single-cycle job start.
- busy_o  out  1  job in progress (not IDLE).
- done_o  out  1  one-cycle pulse when the last result is popped.
- err_timeout_o  out  1  sticky timeout flag, cleared by the next accepted start.
- mac_data_v_o  out  1  MAC operand valid.
- mac_data_mode_o  out  1  1 = weight, 0 = data.
- mac_data_rst_addr_o  out  1  reset the MAC load address; asserted on the first beat of each phase.
- mac_data_o  out  W  MAC operand.
- mac_result_v_i  in  1  MAC result valid.
- mac_result_i  in  W  MAC result.
- res_v_o  out  1  result valid to host.
- res_data_o  out  W  result data.
- res_ready_i  in  1  host accepts result.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: all outputs 0 except in_ready_o = 1. State IDLE; operand count, result count and all pointers 0.
- States: IDLE → LOAD_W → LOAD_D → WAIT_RES → DRAIN → IDLE.
- IDLE loading:
  - in_ready_o = (opnd_cnt < 2·N·N).
  - A beat is accepted when in_v_i && in_ready_o; it is written to buf[opnd_cnt] and opnd_cnt increments.
  - Entries 0..N·N−1 are weights; entries N·N..2·N·N−1 are data.
- Start acceptance:
  - start_i is accepted only in IDLE with opnd_cnt == 2·N·N. Otherwise it is ignored, with no flag.
  - Acceptance clears err_timeout_o and the result count, and moves to LOAD_W on the next edge.
  - If start_i and an in_v_i beat coincide in IDLE, the beat is processed first; the start is evaluated against the pre-beat count.
- LOAD_W:
  - One MAC beat per cycle, all MAC outputs registered.
  - mac_data_v_o = 1, mode = 1, data = buf[k] for k = 0..N·N−1.
  - rst_addr = 1 only for k = 0.
  - The first MAC beat appears the cycle after the start edge.
- LOAD_D:
  - Same as LOAD_W with mode = 0 and entries N·N..2·N·N−1.
  - rst_addr = 1 only on the first data beat.
- Operand outputs outside the load states: mac_data_v_o = 0; mac_data_o, mode and rst_addr hold 0.
- Total load: exactly 2·N·N consecutive valid cycles with no bubbles.
- Result capture:
  - Enabled in LOAD_D and WAIT_RES.
  - Each mac_result_v_i writes rbuf[res_cnt] while res_cnt < N·N; extra beats are dropped.
  - Beats arriving in IDLE, LOAD_W or DRAIN are ignored.
- WAIT_RES:
  - Entered after the last data beat.
  - Timeout counter resets to 0 on entry and on every captured beat, and increments otherwise.
  - res_cnt == N·N → DRAIN.
  - Counter reaching TIMEOUT → err_timeout_o = 1, then DRAIN with only the res_cnt entries captured.
  - If res_cnt == 0 at timeout, go straight to IDLE with done_o pulsed.
- DRAIN:
  - res_v_o = 1 while rd_ptr < res_cnt, with res_data_o = rbuf[rd_ptr].
  - rd_ptr advances on res_v_o && res_ready_i.
  - Data is held stable while stalled.
  - On the last pop: done_o pulses, opnd_cnt = 0, → IDLE.
- busy_o = (state != IDLE). in_ready_o = 0 whenever busy.
- Reset mid-job returns everything to reset values immediately. A partial job is discarded and the MAC sees no further beats.

Decomposition:
- mac_pkg holds:
  - state enum (IDLE, LOAD_W, LOAD_D, WAIT_RES, DRAIN);
  - MODE_WEIGHT = 1, MODE_DATA = 0;
  - derived constants NN = N·N and JOB_LEN = 2·N·N.
- Sub-module mac_seq_buf: parameterised DEPTH×W register file with synchronous write and combinational read. Instantiated twice:
  - operand buffer, DEPTH = JOB_LEN;
  - result buffer, DEPTH = NN.
- FSM, counters and timeout stay in mac_seq.

Test Plan:
- Nominal job:
  - Stimulus: load operands 1..8, pulse start; MAC model returns 0x11, 0x22, 0x33, 0x44 starting 3 cycles after the last data beat; res_ready_i held 1.
  - Required: mac beats mode 1,1,1,1,0,0,0,0 with data 1..8; rst_addr high only on beats 0 and 4; host receives 0x11..0x44 in order; done_o pulses once; busy_o falls the next cycle.
- Early start:
  - Stimulus: load 5 operands, pulse start.
  - Required: state stays IDLE, busy_o = 0, no MAC beat. After 3 more operands plus start, the job runs normally.
- Backpressure:
  - Stimulus: res_ready_i toggles 1,0,0,1,…
  - Required: res_data_o is stable while stalled; all four results are delivered exactly once, in order.
- Timeout:
  - Stimulus: MAC returns only 2 results.
  - Required: err_timeout_o = 1 exactly TIMEOUT = 15 cycles after the 2nd result; 2 results drained; done_o pulses. The next accepted start clears err_timeout_o.
- Excess results:
  - Stimulus: MAC sends 6 result beats.
  - Required: only the first 4 are captured and delivered.
- Reset mid-LOAD_D:
  - Stimulus: assert rst during the second data beat.
  - Required: mac_data_v_o = 0 and in_ready_o = 1 asynchronously; after release, a fresh 8-operand job completes correctly.
